or8way16_seq: RTL and testbench
===============================

OR8WAY16_SEQ -- requirements
Module: or8way16_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 16, data width of every word, accumulator and result.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: start  input  1  request to begin one 8-way OR reduction.
REQ-006 SHALL have port: mask  input  8  participation mask, bit k enables ik.
REQ-007 SHALL have ports: i0..i7  input  WIDTH each  operand words.
REQ-008 SHALL have port: out  output  WIDTH  reduction result.
REQ-009 SHALL have port: out_valid  output  1  result available.
REQ-010 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port: busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE; busy = (state != IDLE).
REQ-013 SHALL accept start only in IDLE: on that edge, capture i0..i7 and mask into operand registers, clear the accumulator, set index to the first scanned position, and enter RUN.
REQ-014 SHALL ignore start in RUN and DONE; the captured operands SHALL NOT change until the next accept.
REQ-015 SHALL, per RUN cycle, apply acc <= acc | word[idx] when mask[idx]=1, leave acc unchanged when mask[idx]=0, then advance idx.
REQ-016 SHALL scan idx in ascending order 0..7 with no wrap-around; after processing idx 7 SHALL enter DONE on that same edge.
REQ-017 SHALL, in DONE, drive out = acc and out_valid = 1, holding both stable until out_ready = 1.
REQ-018 SHALL, in DONE with out_ready = 1, return to IDLE on that edge and deassert out_valid; start on that same edge is ignored.
REQ-019 SHALL drive out_valid = 0 in IDLE and RUN; out SHALL hold the last result in IDLE and RUN.
REQ-020 SHALL, with mask = 8'h00, produce out = 0.

Reset
REQ-021 SHALL, on reset assertion at any time including mid-RUN or DONE, immediately force state IDLE, out = 0, out_valid = 0, busy = 0, acc = 0, idx = 0, and operand/mask registers = 0.
REQ-022 SHALL treat the first rising clk edge after reset deasserts as a normal IDLE cycle, so start sampled at that edge is accepted.

Configuration
REQ-023 SHALL support macro OR8WAY16_SEQ_SKIP_EN.
REQ-024 SHALL, without OR8WAY16_SEQ_SKIP_EN, always spend exactly 8 RUN cycles, so out_valid rises on the 8th edge after the accept edge regardless of mask.
REQ-025 SHALL, with OR8WAY16_SEQ_SKIP_EN, start at and jump idx to the next set mask bit, spending popcount(mask) RUN cycles.
REQ-026 SHALL, with OR8WAY16_SEQ_SKIP_EN and mask = 0, go directly from IDLE to DONE on the accept edge, so out = 0 and out_valid = 1 immediately after that edge.

Structure
REQ-027 SHALL place state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the way count 8 and the index width 3 in shared package or8way16_seq_pkg.
REQ-028 SHALL compute the accumulator update with one instance of existing sub-module or16 (time-shared and fed by an 8:1 operand mux), not with eight parallel OR trees.

Verification
REQ-029 SHALL check: i0..i7 = 16'h0001<<k, mask = FF, out_ready = 1 -> out = 16'h00FF, out_valid after 8 edges (non-SKIP).
REQ-030 SHALL check: mask = 8'h81, i0 = 16'h8000, i7 = 16'h0001, all others = FFFF -> out = 16'h8001; 8 edges non-SKIP, 2 edges SKIP.
REQ-031 SHALL check: out_ready = 0 for 5 cycles in DONE with start pulsed -> out and out_valid stable, no restart; out_ready = 1 -> IDLE next edge.
REQ-032 SHALL check: reset asserted asynchronously at RUN idx 4 -> out = 0, out_valid = 0, busy = 0 before the next clk edge; a new start then yields the correct result.
REQ-033 SHALL check: mask = 00 -> out = 16'h0000; out_valid after 8 edges non-SKIP, immediately after the accept edge with SKIP.
REQ-034 SHALL check: i0..i7 changed during RUN -> result reflects only the values captured at accept.

Source files
------------

// File: rtl/or8way16_seq_pkg.sv
// Shared types and constants for the sequential 8-way OR reducer.
// Holds the FSM encoding, way count, index width and the mask scan helper.
package or8way16_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int WAYS = 8;
  localparam int IDXW = 3;

  // Lowest set mask bit at or above 'from'; returns WAYS when none is left.
  function automatic logic [IDXW:0] next_set(
    input logic [WAYS-1:0] m,
    input logic [IDXW:0]   from
  );
    logic [IDXW:0] r;
    r = (IDXW+1)'(WAYS);
    for (int i = WAYS-1; i >= 0; i--) begin
      if (m[i] && (i >= int'(from))) begin
        r = (IDXW+1)'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/or8way16_seq_or16.sv
// Word-wide two-input OR, shared by every step of the reduction.
// One instance is time-multiplexed by the reducer's operand mux.
module or16 #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a | b;

endmodule

// File: rtl/or8way16_seq.sv
// Sequential masked 8-way OR reduction, one operand word per RUN cycle.
// Define OR8WAY16_SEQ_SKIP_EN to visit only the words whose mask bit is set.
module or8way16_seq
  import or8way16_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       mask,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  input  logic [WIDTH-1:0] i4,
  input  logic [WIDTH-1:0] i5,
  input  logic [WIDTH-1:0] i6,
  input  logic [WIDTH-1:0] i7,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  state_e state;
  state_e state_nx;

  logic [WAYS-1:0][WIDTH-1:0] ops;
  logic [WAYS-1:0]            msk;
  logic [WIDTH-1:0]           acc;
  logic [WIDTH-1:0]           res;
  logic [WIDTH-1:0]           term;
  logic [WIDTH-1:0]           acc_nx;
  logic [IDXW-1:0]            idx;
  logic [IDXW-1:0]            idx_step;
  logic [IDXW-1:0]            idx_first;
  logic                       last;
  logic                       start_done;

  // Masked-off words feed zero so the accumulator is left unchanged.
  assign term = msk[idx] ? ops[idx] : '0;

  or16 #(.WIDTH(WIDTH)) u_or (
    .a (acc),
    .b (term),
    .y (acc_nx)
  );

`ifdef OR8WAY16_SEQ_SKIP_EN
  logic [IDXW:0] nxt;
  logic [IDXW:0] first;

  assign nxt        = next_set(msk, {1'b0, idx} + 1'b1);
  assign last       = nxt[IDXW];
  assign idx_step   = nxt[IDXW-1:0];
  assign first      = next_set(mask, '0);
  assign start_done = first[IDXW];
  assign idx_first  = first[IDXW-1:0];
`else
  assign last       = (idx == IDXW'(WAYS-1));
  assign idx_step   = idx + 1'b1;
  assign start_done = 1'b0;
  assign idx_first  = '0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state: accept in IDLE, scan in RUN, wait for consumer in DONE.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nx = start_done ? DONE : RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, accumulation and result latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ops <= '0;
      msk <= '0;
      acc <= '0;
      idx <= '0;
      res <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ops <= {i7, i6, i5, i4, i3, i2, i1, i0};
            msk <= mask;
            acc <= '0;
            idx <= idx_first;
            if (start_done) begin
              res <= '0;
            end
          end
        end
        RUN: begin
          acc <= acc_nx;
          idx <= last ? '0 : idx_step;
          if (last) begin
            res <= acc_nx;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign out       = res;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_or8way16_seq.sv
// Directed and randomized checks of or8way16_seq against a reference model.
// Build with OR8WAY16_SEQ_SKIP_EN defined to check the skipping variant.
module tb_or8way16_seq;

  localparam int W = 16;
`ifdef OR8WAY16_SEQ_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         out_ready = 1'b0;
  logic [7:0]   mask = '0;
  logic [W-1:0] w [8];
  logic [W-1:0] out;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] last_res = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  or8way16_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mask      (mask),
    .i0        (w[0]),
    .i1        (w[1]),
    .i2        (w[2]),
    .i3        (w[3]),
    .i4        (w[4]),
    .i5        (w[5]),
    .i6        (w[6]),
    .i7        (w[7]),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_or(input logic [7:0] m);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      if (m[k]) r = r | w[k];
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [7:0] m);
    return SKIP ? $countones(m) : 8;
  endfunction

  task automatic do_op(input logic [7:0] m, input bit scr, input int hold,
                       input bit rel, input string tag);
    logic [W-1:0] e;
    int lat;
    int n;
    e   = model_or(m);
    lat = model_lat(m);
    @(negedge clk);
    if (rel) reset = 1'b0;
    mask  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scr) begin
      for (int k = 0; k < 8; k++) w[k] = W'($urandom);
    end
    chk({tag, "_busy_acc"}, 32'(busy), 32'd1);
    if (lat > 0) begin
      chk({tag, "_vld_run"}, 32'(out_valid), 32'd0);
      chk({tag, "_out_run"}, 32'(out), 32'(last_res));
    end
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_out"}, 32'(out), 32'(e));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      start = 1'b1;
      mask  = 8'($urandom);
      for (int k = 0; k < 8; k++) w[k] = W'($urandom);
      @(posedge clk);
      #1;
      chk({tag, "_hold_out"}, 32'(out), 32'(e));
      chk({tag, "_hold_vld"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_busy"}, 32'(busy), 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_vld_rel"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy_rel"}, 32'(busy), 32'd0);
    chk({tag, "_out_rel"}, 32'(out), 32'(e));
    @(negedge clk);
    out_ready = 1'b0;
    start     = 1'b0;
    last_res  = e;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) w[k] = '0;
    #12;
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 8; k++) w[k] = W'(16'h0001 << k);
    do_op(8'hFF, 1'b0, 0, 1'b0, "onehot");

    for (int k = 0; k < 8; k++) w[k] = 16'hFFFF;
    w[0] = 16'h8000;
    w[7] = 16'h0001;
    do_op(8'h81, 1'b0, 5, 1'b0, "ends");

    for (int k = 0; k < 8; k++) w[k] = W'(16'h0100 << (k % 8));
    @(negedge clk);
    mask  = 8'hFF;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_out", 32'(out), 32'd0);
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    last_res = '0;

    for (int k = 0; k < 8; k++) w[k] = W'($urandom);
    do_op(8'h3C, 1'b0, 0, 1'b1, "post_rst");

    for (int k = 0; k < 8; k++) w[k] = 16'hFFFF;
    do_op(8'h00, 1'b0, 0, 1'b0, "mask0");

    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) w[k] = W'($urandom);
      do_op(8'($urandom), 1'b1, r % 3, 1'b0, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
